store_narrow_buffer: RTL and testbench
======================================

// Module: store_narrow_buffer
// PURPOSE
//  MEM-stage store path: the narrowing counterpart of load-side sign/zero extension.
//  Accepts 32-bit register data with SB/SH/SW size and narrows/replicates it onto byte lanes with byte enables.
//  Queues stores in a small in-order FIFO.
//  Drains the FIFO to data memory over a valid/ready handshake.
//  Sits between the EX/MEM pipeline register and the data memory write port.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  st_valid     in   1   store request from MEM stage
//  st_ready     out  1   buffer can accept a request this cycle
//  st_addr      in   32  byte address of store
//  st_data      in   32  register value (rt)
//  st_size      in   2   00=byte(SB) 01=half(SH) 10=word(SW) 11=reserved
//  st_misalign  out  1   one-cycle pulse: previous accepted request was rejected
//  mem_valid    out  1   head entry presented to memory
//  mem_ready    in   1   memory takes head entry this cycle
//  mem_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated write data
//  mem_be       out  4   byte enables; be[0] = bits 7:0 = addr[1:0]==00 (little-endian lanes)
//  count        out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//  empty        out  1   count==0
//  full         out  1   count==DEPTH
// BEHAVIOUR
//  Reset (async, rst_n=0): all entries discarded.
//   - Pointers and count go to 0.
//   - mem_valid=0, st_misalign=0, empty=1, full=0.
//   - mem_addr/mem_wdata/mem_be = 0.
//   - Takes effect mid-drain; no partial write is retained.
//  Handshake:
//   - st_ready = !full (registered state, no same-cycle bypass).
//   - Transfer when st_valid&&st_ready.
//   - mem_valid = !empty. Pop when mem_valid&&mem_ready.
//   - Head outputs hold stable while mem_valid&&!mem_ready.
//   - When empty, mem_addr/wdata/be are forced to 0.
//  Narrowing at enqueue:
//   - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
//   - half: wdata={2{d[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
//   - word: wdata=d, be=4'b1111.
//   - Upper data bits beyond the size are ignored; no overflow check.
//  Rejection:
//   - Conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11.
//   - A rejected request completes the handshake but is NOT enqueued.
//   - st_misalign=1 in the following cycle only; count unchanged.
//  Latency:
//   - An accepted store appears at the head no earlier than the next cycle.
//   - Empty, push at cycle N -> mem_valid=1 at N+1.
//  Order: strictly FIFO; pointers wrap modulo DEPTH.
//  Simultaneous push and pop:
//   - Both occur; count unchanged.
//   - Legal at any count < DEPTH, including count==1.
//   - Head advances to the next entry while the new entry lands at the tail.
//   - At count==DEPTH push is blocked (st_ready=0); pop-only proceeds.
//   - st_ready rises the cycle after the pop.
//  count/empty/full are registered and change only on clk or reset.
// TESTING
//  1. Reset, then SB addr=0x1003 data=0xAABBCCDD
//     -> next cycle mem_valid=1, mem_addr=0x1000, wdata=0xDDDDDDDD, be=1000.
//  2. SH addr=0x2002 data=0x12345678, mem_ready=1
//     -> wdata=0x56785678, be=1100, mem_addr=0x2000; popped same cycle, empty=1 after.
//  3. SW addr=0x3001
//     -> not enqueued, st_misalign=1 exactly one cycle, count stays 0, mem_valid stays 0.
//     Repeat with SH addr=0x3001 and with size=11: same response.
//  4. mem_ready=0, push 4 words
//     -> full=1, st_ready=0, count=4; 5th request held off.
//     Raise mem_ready 1 cycle -> head popped in order, st_ready=1 next cycle.
//  5. count=2, push and pop same cycle -> count stays 2; data order preserved.
//     Then 8 push/pop cycles verify pointer wrap.
//  6. count=3, assert rst_n=0 mid-drain
//     -> immediately mem_valid=0, count=0, empty=1.
//     After release, first push yields only the new entry.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: sizes register data onto byte lanes with byte
// enables, queues stores in an in-order FIFO, and drains them to data memory
// over a valid/ready handshake.
module store_narrow_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [1:0]               st_size,
   output logic                     st_misalign,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_be,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } entry_t;

   entry_t             fifo_q [DEPTH];
   entry_t             head_q;
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               empty_q;
   logic               full_q;
   logic               misalign_q;

   entry_t             new_c;
   entry_t             head_nxt_c;
   logic               bad_c;
   logic               accept_c;
   logic               push_c;
   logic               pop_c;
   logic [PTR_W-1:0]   rd_next_c;
   logic [CNT_W-1:0]   count_nxt_c;

   // Narrow/replicate the incoming store onto byte lanes and flag illegal alignment
   always_comb begin
      new_c       = '0;
      bad_c       = 1'b0;
      new_c.waddr = st_addr[31:2];
      case (st_size)
         2'b00: begin
            new_c.wdata = {4{st_data[7:0]}};
            new_c.be    = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            new_c.wdata = {2{st_data[15:0]}};
            new_c.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            bad_c       = st_addr[0];
         end
         2'b10: begin
            new_c.wdata = st_data;
            new_c.be    = 4'b1111;
            bad_c       = |st_addr[1:0];
         end
         default: begin
            bad_c = 1'b1;
         end
      endcase
   end

   // Handshake decode, occupancy update and next head entry
   always_comb begin
      accept_c    = st_valid && !full_q;
      push_c      = accept_c && !bad_c;
      pop_c       = !empty_q && mem_ready;
      rd_next_c   = rd_ptr_q + PTR_W'(1);
      count_nxt_c = count_q;
      head_nxt_c  = head_q;
      case ({push_c, pop_c})
         2'b10:   count_nxt_c = count_q + CNT_W'(1);
         2'b01:   count_nxt_c = count_q - CNT_W'(1);
         default: count_nxt_c = count_q;
      endcase
      // The new entry becomes head directly when nothing older remains ahead of it
      if (count_nxt_c == '0) begin
         head_nxt_c = '0;
      end else if (push_c && (empty_q || (pop_c && count_q == CNT_W'(1)))) begin
         head_nxt_c = new_c;
      end else if (pop_c) begin
         head_nxt_c = fifo_q[rd_next_c];
      end
   end

   // Control state and registered head entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         misalign_q <= 1'b0;
         head_q     <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_next_c;
         count_q    <= count_nxt_c;
         empty_q    <= (count_nxt_c == '0);
         full_q     <= (count_nxt_c == CNT_W'(DEPTH));
         misalign_q <= accept_c && bad_c;
         head_q     <= head_nxt_c;
      end
   end

   // Entry storage; reset only needs to clear the pointers
   always_ff @(posedge clk) begin
      if (push_c) fifo_q[wr_ptr_q] <= new_c;
   end

   assign st_ready    = !full_q;
   assign st_misalign = misalign_q;
   assign mem_valid   = !empty_q;
   assign mem_addr    = {head_q.waddr, 2'b00};
   assign mem_wdata   = head_q.wdata;
   assign mem_be      = head_q.be;
   assign count       = count_q;
   assign empty       = empty_q;
   assign full        = full_q;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Bench for store_narrow_buffer: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_store_narrow_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic        st_misalign;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [2:0]  count;
   logic        empty;
   logic        full;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } ent_t;

   ent_t model_q[$];
   logic exp_mis;
   int   n_checks;
   int   n_errors;

   store_narrow_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_size(st_size), .st_misalign(st_misalign),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .count(count), .empty(empty), .full(full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_bad(input logic [31:0] a, input logic [1:0] sz);
      case (sz)
         2'b00:   return 1'b0;
         2'b01:   return a[0];
         2'b10:   return a[1:0] != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   // Lane view: the access covers nbytes lanes starting at its offset inside the
   // word; every lane carries the data byte that belongs to its position modulo size.
   function automatic ent_t expect_entry(input logic [31:0] a, input logic [31:0] d,
                                         input logic [1:0] sz);
      ent_t e;
      int   nbytes;
      int   off;
      nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      off    = (nbytes == 1) ? int'(a[1:0]) : (nbytes == 2) ? 2 * int'(a[1]) : 0;
      e.addr = {a[31:2], 2'b00};
      e.be   = '0;
      e.wdata = '0;
      for (int i = 0; i < 4; i++) begin
         e.be[i] = (i >= off) && (i < off + nbytes);
         e.wdata[8*i +: 8] = d[8*(i % nbytes) +: 8];
      end
      return e;
   endfunction

   // Monitor: compare DUT state with the model, then advance the model over the next edge
   initial begin
      exp_mis = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_q.delete();
            exp_mis = 1'b0;
         end
         chk("mem_valid", 32'(mem_valid), 32'(model_q.size() != 0));
         chk("count",     32'(count),     32'(model_q.size()));
         chk("empty",     32'(empty),     32'(model_q.size() == 0));
         chk("full",      32'(full),      32'(model_q.size() == DEPTH));
         chk("st_ready",  32'(st_ready),  32'(model_q.size() != DEPTH));
         chk("st_misalign", 32'(st_misalign), 32'(exp_mis));
         if (model_q.size() != 0) begin
            chk("mem_addr",  mem_addr,       model_q[0].addr);
            chk("mem_wdata", mem_wdata,      model_q[0].wdata);
            chk("mem_be",    32'(mem_be),    32'(model_q[0].be));
         end else begin
            chk("idle_bus", mem_addr | mem_wdata | 32'(mem_be), 32'h0);
         end
         if (rst_n) begin
            logic take;
            logic pop;
            take    = st_valid && (model_q.size() < DEPTH);
            pop     = (model_q.size() != 0) && mem_ready;
            exp_mis = take && is_bad(st_addr, st_size);
            if (pop) void'(model_q.pop_front());
            if (take && !is_bad(st_addr, st_size))
               model_q.push_back(expect_entry(st_addr, st_data, st_size));
         end
      end
   end

   task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic mr);
      st_valid  = v;
      st_addr   = a;
      st_data   = d;
      st_size   = sz;
      mem_ready = mr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic mr, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 2'b00, mr);
   endtask

   initial begin
      logic [1:0]  bad_sz [3];
      logic [31:0] rnd_a;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_empty", 32'(empty), 32'h1);
      chk("reset_count", 32'(count), 32'h0);
      rst_n = 1'b1;
      idle(1'b0, 1);

      // 1: byte store at top lane
      cyc(1'b1, 32'h0000_1003, 32'hAABB_CCDD, 2'b00, 1'b0);
      chk("t1_valid", 32'(mem_valid), 32'h1);
      chk("t1_addr",  mem_addr, 32'h0000_1000);
      chk("t1_wdata", mem_wdata, 32'hDDDD_DDDD);
      chk("t1_be",    32'(mem_be), 32'h8);
      idle(1'b1, 2);

      // 2: upper half store, popped in the cycle it is presented
      cyc(1'b1, 32'h0000_2002, 32'h1234_5678, 2'b01, 1'b1);
      chk("t2_wdata", mem_wdata, 32'h5678_5678);
      chk("t2_be",    32'(mem_be), 32'hC);
      chk("t2_addr",  mem_addr, 32'h0000_2000);
      idle(1'b1, 1);
      chk("t2_empty", 32'(empty), 32'h1);

      // 3: rejected requests
      bad_sz[0] = 2'b10; bad_sz[1] = 2'b01; bad_sz[2] = 2'b11;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 32'h0000_3001, 32'hCAFE_F00D, bad_sz[k], 1'b0);
         chk("t3_mis",   32'(st_misalign), 32'h1);
         chk("t3_count", 32'(count), 32'h0);
         chk("t3_valid", 32'(mem_valid), 32'h0);
         idle(1'b0, 1);
         chk("t3_mis_off", 32'(st_misalign), 32'h0);
      end

      // 4: fill, hold off a fifth request, then a single pop
      for (int k = 0; k < 4; k++)
         cyc(1'b1, 32'h0000_4000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 2'b10, 1'b0);
      chk("t4_full",  32'(full), 32'h1);
      chk("t4_ready", 32'(st_ready), 32'h0);
      chk("t4_count", 32'(count), 32'h4);
      cyc(1'b1, 32'h0000_5000, 32'h5555_5555, 2'b10, 1'b0);
      cyc(1'b1, 32'h0000_5000, 32'h5555_5555, 2'b10, 1'b0);
      chk("t4_held", 32'(count), 32'h4);
      idle(1'b1, 1);
      chk("t4_ready_up", 32'(st_ready), 32'h1);
      chk("t4_head2",    mem_addr, 32'h0000_4004);
      idle(1'b1, 4);

      // 5: steady push+pop at count 2, wrapping the pointers
      cyc(1'b1, 32'h0000_6000, 32'h6000_0000, 2'b10, 1'b0);
      cyc(1'b1, 32'h0000_6004, 32'h6000_0001, 2'b10, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 32'h0000_7000 + 32'(k), 32'h7000_0000 + 32'(k), 2'b00, 1'b1);
         chk("t5_count", 32'(count), 32'h2);
      end
      idle(1'b1, 3);

      // 6: reset in the middle of a drain
      for (int k = 0; k < 3; k++)
         cyc(1'b1, 32'h0000_8000 + 32'(4 * k), 32'h8000_0000 + 32'(k), 2'b10, 1'b0);
      st_valid = 1'b0; mem_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_valid", 32'(mem_valid), 32'h0);
      chk("t6_count", 32'(count), 32'h0);
      chk("t6_empty", 32'(empty), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b1, 32'h0000_9000, 32'h9999_0000, 2'b10, 1'b0);
      chk("t6_new",   mem_wdata, 32'h9999_0000);
      chk("t6_cnt1",  32'(count), 32'h1);
      idle(1'b1, 2);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         rnd_a = $urandom;
         if ($urandom_range(0, 3) != 0) rnd_a[1:0] = 2'b00;
         cyc(1'($urandom_range(0, 9) < 6), rnd_a, $urandom,
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) < 5));
      end
      idle(1'b1, DEPTH + 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
